// File: rtl/cpu_types_pkg.sv
// Shared instruction-cache types: address field split, geometry constants and FSM states.
package cpu_types_pkg;

  localparam int unsigned SETS   = 16;
  localparam int unsigned IIDX_W = 4;
  localparam int unsigned ITAG_W = 32 - IIDX_W - 2;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_frames.sv
// Tag/data/valid storage for the direct-mapped icache: one async read port, one write port.
module icache_frames
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic [IIDX_W-1:0] ridx_i,
  output logic              rd_valid_c_o,
  output logic [ITAG_W-1:0] rd_tag_c_o,
  output logic [31:0]       rd_data_c_o,
  input  logic              wen_i,
  input  logic [IIDX_W-1:0] widx_i,
  input  logic [ITAG_W-1:0] wtag_i,
  input  logic [31:0]       wdata_i
);

  logic [SETS-1:0]   valid_q;
  logic [ITAG_W-1:0] tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  // Only the valid bits need a reset; tag/data are qualified by them.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (wen_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wen_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign rd_valid_c_o = valid_q[ridx_i];
  assign rd_tag_c_o   = tag_q[ridx_i];
  assign rd_data_c_o  = data_q[ridx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one word per frame, single outstanding fill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  icache_state_t     state_q, state_d;
  icachef_t          req;
  icachef_t          miss_q, miss_d;
  logic              hit_c;
  logic              fill_c;
  logic              rd_valid;
  logic [ITAG_W-1:0] rd_tag;
  logic [31:0]       rd_data;
  logic              unused_bytoff;

  assign req           = icachef_t'(imemaddr);
  assign unused_bytoff = ^req.bytoff;

  icache_frames u_frames (
    .CLK          (CLK),
    .nRST         (nRST),
    .ridx_i       (req.idx),
    .rd_valid_c_o (rd_valid),
    .rd_tag_c_o   (rd_tag),
    .rd_data_c_o  (rd_data),
    .wen_i        (fill_c),
    .widx_i       (miss_q.idx),
    .wtag_i       (miss_q.tag),
    .wdata_i      (iload)
  );

  // Hit under miss is allowed except on the frame currently being refilled.
  always_comb begin
    hit_c = imemREN && rd_valid && (rd_tag == req.tag);
    if ((state_q == FETCH) && (req.idx == miss_q.idx)) begin
      hit_c = 1'b0;
    end
  end

  assign ihit     = hit_c;
  assign imemload = hit_c ? rd_data : 32'd0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
    end
  end

  // A started fill always completes, even if the fetch address moves on.
  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    fill_c  = 1'b0;
    iREN    = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN && !hit_c) begin
          miss_d        = req;
          miss_d.bytoff = 2'b00;
          state_d       = FETCH;
        end
      end
      FETCH: begin
        iREN = 1'b1;
        if (!iwait) begin
          fill_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign iaddr = 32'(miss_q);

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Saturating event counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if ((state_q == IDLE) && hit_c && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if ((state_q == IDLE) && (state_d == FETCH) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: random fetch stream against a behavioural cache/memory model.
module tb_icache;

  logic        CLK      = 1'b0;
  logic        nRST     = 1'b0;
  logic        imemREN  = 1'b0;
  logic [31:0] imemaddr = 32'd0;
  logic        iwait    = 1'b1;
  logic [31:0] iload    = 32'd0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iwait    (iwait),
    .iload    (iload),
    .iREN     (iREN),
    .iaddr    (iaddr)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          w;
  } miss_t;

  exp_t        sb_q[$];
  miss_t       mq[$];
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  int          checks = 0;
  int          errors = 0;
  int          req_id = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0004;
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[31:6]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Call at posedge+1; hit latency is 0, or 1 + memory wait + 1 on a miss.
  task automatic start(input logic [31:0] a, input int w, input bit track, input bit lat_known);
    bit    h;
    exp_t  e;
    miss_t m;
    logic [31:0] wa;
    wa = a & 32'hFFFF_FFFC;
    h  = model_hit(a);
    if (track) begin
      e.data = mem_f(wa);
      e.lat  = !lat_known ? -1 : (h ? 0 : w + 2);
      sb_q.push_back(e);
    end
    if (!h) begin
      m.addr = wa;
      m.w    = w;
      mq.push_back(m);
    end
    imemaddr = a;
    imemREN  = 1'b1;
    req_id++;
  endtask

  task automatic wait_hit();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      #1;
      if (ihit) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wait_hit: no ihit within 80 cycles for addr %h", imemaddr);
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pop an expectation on each presented hit.
  int   mon_cyc  = 0;
  int   mon_last = -1;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (req_id != mon_last) begin
        mon_last = req_id;
        mon_cyc  = 0;
      end else begin
        mon_cyc++;
      end
      if (imemREN && ihit) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hit: addr %h data %h", imemaddr, imemload);
        end else begin
          mon_e = sb_q.pop_front();
          chk("hit_data", imemload, mon_e.data);
          if (mon_e.lat >= 0) chk("hit_latency", 32'(mon_cyc), 32'(mon_e.lat));
        end
      end else begin
        chk("nohit_load", imemload, 32'd0);
        if (!imemREN) chk("noreq_hit", 32'(ihit), 32'd0);
      end
    end
  end

  // Memory responder: holds iwait for the chosen wait, then returns the word and installs it in the model.
  int          r_cnt = 0;
  logic [31:0] r_addr;
  initial begin
    forever begin
      @(negedge CLK);
      if (!iREN) begin
        r_cnt = 0;
        iwait = 1'b1;
        iload = $urandom;
      end else if (mq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch: iaddr %h", iaddr);
        iwait = 1'b0;
        iload = 32'd0;
      end else begin
        r_addr = mq[0].addr;
        chk("fill_addr", iaddr, r_addr);
        if (r_cnt < mq[0].w) begin
          iwait = 1'b1;
          iload = $urandom;
          r_cnt++;
        end else begin
          iwait = 1'b0;
          iload = mem_f(r_addr);
          @(posedge CLK);
          m_valid[r_addr[5:2]] = 1'b1;
          m_tag[r_addr[5:2]]   = r_addr[31:6];
          void'(mq.pop_front());
          r_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] ra;
  logic [25:0] rtag;
  initial begin
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    @(negedge CLK);
    #1;
    chk("rst_iREN", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Cold miss with 3 wait cycles, then refetch hit.
    start(32'h0000_0000, 3, 1'b1, 1'b1); wait_hit();
    start(32'h0000_0000, 0, 1'b1, 1'b1); wait_hit();

    // Conflict on idx 1.
    start(32'h0000_0004, 1, 1'b1, 1'b1); wait_hit();
    start(32'h0000_0044, 2, 1'b1, 1'b1); wait_hit();
    start(32'h0000_0004, 0, 1'b1, 1'b1); wait_hit();

    // Redirect mid-fill with hit-under-miss on another frame.
    start(32'h0000_0010, 4, 1'b0, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    start(32'h0000_0000, 0, 1'b1, 1'b1); wait_hit();
    start(32'h0000_0020, 1, 1'b1, 1'b0); wait_hit();
    start(32'h0000_0010, 0, 1'b1, 1'b1); wait_hit();

    // Frame being refilled must not hit even with a stale match.
    start(32'h0000_0084, 3, 1'b0, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    imemaddr = 32'h0000_0004;
    req_id++;
    repeat (2) begin
      @(negedge CLK);
      #1;
      chk("collision_hit", 32'(ihit), 32'd0);
    end
    imemREN = 1'b0;
    req_id++;
    repeat (6) @(posedge CLK);
    #1;
    start(32'h0000_0004, 1, 1'b1, 1'b1); wait_hit();

    // Random fetch stream over a small tag set so conflicts and refetches are common.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       rtag = 26'h0;
        1:       rtag = 26'h1;
        2:       rtag = 26'h2;
        default: rtag = 26'h3FF_FFFF;
      endcase
      ra = {rtag, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      start(ra, $urandom_range(0, 3), 1'b1, 1'b1);
      wait_hit();
      if ($urandom_range(0, 3) == 0) begin
        imemREN = 1'b0;
        req_id++;
        @(posedge CLK);
        #1;
      end
    end

    // Reset in the middle of a long fill.
    start(32'h0000_0108, 20, 1'b0, 1'b1);
    repeat (3) @(posedge CLK);
    #2;
    nRST    = 1'b0;
    imemREN = 1'b0;
    req_id++;
    #1;
    chk("midrst_iREN", 32'(iREN), 32'd0);
    chk("midrst_iaddr", iaddr, 32'd0);
    chk("midrst_ihit", 32'(ihit), 32'd0);
    mq.delete();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // One miss then hits; 0x0 must miss after reset.
    start(32'h0000_0000, 0, 1'b1, 1'b1); wait_hit();
    repeat (4) begin
      start(32'h0000_0000, 0, 1'b1, 1'b1); wait_hit();
    end
    imemREN = 1'b0;
    req_id++;
    @(posedge CLK);
    #1;
`ifdef ICACHE_STATS_EN
    chk("miss_count", miss_count, 32'd1);
    chk("hit_count", hit_count, 32'd5);
`endif
    repeat (3) @(negedge CLK);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("mq_drained", 32'(mq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
